seq_shift_unit: RTL

//  Multi-cycle parametrised shifter for the processor datapath. Generalises the fixed

---
 rtl/seq_shift_unit_pkg.sv | 17 +
 rtl/seq_shift_unit_step.sv | 30 +++
 rtl/seq_shift_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/seq_shift_unit_pkg.sv
// Shared encodings for the multi-cycle shifter: shift modes and controller states.
package seq_shift_unit_pkg;

  typedef enum logic [1:0] {
    MODE_SLL  = 2'b00,
    MODE_SRL  = 2'b01,
    MODE_SRA  = 2'b10,
    MODE_ROTL = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shift_unit_step.sv
// Combinational single-step shifter: moves data by 0..STEP bit positions in the given mode.
module seq_shift_unit_step
  import seq_shift_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int AMT_W = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amt_i,
  input  shift_mode_e      mode_i,
  output logic [WIDTH-1:0] data_o
);

  logic [2*WIDTH-1:0] rot_w;

  always_comb begin
    // Upper half of the doubled word shifted left is the rotate-left result.
    rot_w  = {data_i, data_i} << amt_i;
    data_o = data_i;
    case (mode_i)
      MODE_SLL:  data_o = data_i << amt_i;
      MODE_SRL:  data_o = data_i >> amt_i;
      MODE_SRA:  data_o = $signed(data_i) >>> amt_i;
      MODE_ROTL: data_o = rot_w[2*WIDTH-1:WIDTH];
      default:   data_o = data_i;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROTL shifter, up to STEP bits per clock, with request/result handshakes.
module seq_shift_unit
  import seq_shift_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int AMT_W = $clog2(STEP + 1);

  // Handshakes: a transfer happens on an edge where valid and ready are both high;
  // valid may not depend on ready, and the sender holds its payload until the transfer.

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  shift_mode_e        mode_q, mode_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [AMT_W-1:0]   amt;
  logic [WIDTH-1:0]   step_out;

  seq_shift_unit_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AMT_W (AMT_W)
  ) u_step (
    .data_i (acc_q),
    .amt_i  (amt),
    .mode_i (mode_q),
    .data_o (step_out)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    amt        = (rem_q < SHAMT_W'(STEP)) ? AMT_W'(rem_q) : AMT_W'(STEP);
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d  = in_data;
          rem_d  = in_shamt;
          mode_d = shift_mode_e'(in_mode);
          if (in_shamt == '0) begin
            state_d    = S_DONE;
            out_data_d = in_data;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        acc_d = step_out;
        rem_d = rem_q - SHAMT_W'(amt);
        // The result register only changes on completion so it holds through IDLE and SHIFT.
        if (rem_q == SHAMT_W'(amt)) begin
          state_d    = S_DONE;
          out_data_d = step_out;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      rem_q      <= '0;
      mode_q     <= MODE_SLL;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      mode_q     <= mode_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign dbg_state = state_q;

endmodule
